// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file write-back slice.
//   XLEN_DEF  default result / write-port width
//   REG_AW    register address width (32 architectural registers)
//   REG_ZERO  hard-wired zero register, never written
//   wb_src_e  which producer owns the FIFO push slot this cycle
package regfile_writeback_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;
  localparam int REG_ZERO = 0;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_ALU  = 2'd2
  } wb_src_e;
endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// Synchronous FIFO of {rd, data} write-back entries.
//   clk, rst      clock, async active-high reset (pointers/count only)
//   push/push_data  enqueue (ignored when full)
//   pop           dequeue head (ignored when empty)
//   head_data     current head entry (undefined content when empty)
//   full, empty, count  occupancy status
//   age_view      (WB_FORWARD_EN only) entries in age order, index 0 = head
module regfile_writeback_wb_fifo #(
  parameter int DW    = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef WB_FORWARD_EN
  ,
  output logic [DEPTH-1:0][DW-1:0] age_view
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] r_mem;
  logic [AW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [AW:0]              r_count;
  logic                     w_push, w_pop;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign head_data = r_mem[r_rd_ptr];

  // Payload carries no reset: only occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign age_view[k] = r_mem[r_rd_ptr + AW'(k)];
  end
`endif
endmodule

// File: rtl/regfile_writeback.sv
// Write side of the 32x32 register file. Arbitrates MEM/ALU results into a
// small FIFO, drains the FIFO head onto the single register-file write port
// and keeps a busy scoreboard for decode RAW stalls.
//   clk, rst                         clock, async active-high reset
//   mem_valid/ready/rd/data          load-unit result handshake (priority)
//   alu_valid/ready/rd/data          ALU result handshake
//   issue_valid/issue_rd             decode marks a destination busy
//   wb_stall                         hold the FIFO head this cycle
//   write_enable/addr/data           register-file write port
//   busy_mask                        pending-write scoreboard, bit 0 always 0
//   wb_count                         FIFO occupancy
// Optional: define WB_FORWARD_EN to add a two-port combinational lookup of
// queued results (fwd_addr1/2 -> fwd_hit1/2, fwd_data1/2).
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [REG_AW-1:0]      mem_rd,
  input  logic [XLEN-1:0]        mem_data,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_AW-1:0]      alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   issue_valid,
  input  logic [REG_AW-1:0]      issue_rd,
  input  logic                   wb_stall,
  output logic                   write_enable,
  output logic [REG_AW-1:0]      write_addr,
  output logic [XLEN-1:0]        write_data,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [$clog2(DEPTH):0] wb_count
`ifdef WB_FORWARD_EN
  ,
  input  logic [REG_AW-1:0]      fwd_addr1,
  input  logic [REG_AW-1:0]      fwd_addr2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [XLEN-1:0]        fwd_data1,
  output logic [XLEN-1:0]        fwd_data2
`endif
);
  localparam int DW = REG_AW + XLEN;
  localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

  wb_src_e               w_src;
  logic                  w_full, w_empty, w_push;
  logic [REG_AW-1:0]     w_push_rd;
  logic [XLEN-1:0]       w_push_data;
  logic [DW-1:0]         w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic [NUM_REGS-1:0]   r_busy, w_busy_next;
`ifdef WB_FORWARD_EN
  logic [DEPTH-1:0][DW-1:0] w_age;
`endif

  // Ready depends only on registered full, so a pop on a full edge frees a
  // slot for the following cycle rather than the current one.
  assign mem_ready = !w_full;
  assign alu_ready = !w_full && !mem_valid;

  always_comb begin
    w_src       = SRC_NONE;
    w_push_rd   = mem_rd;
    w_push_data = mem_data;
    if (mem_valid && mem_ready) begin
      w_src = SRC_MEM;
    end else if (alu_valid && alu_ready) begin
      w_src       = SRC_ALU;
      w_push_rd   = alu_rd;
      w_push_data = alu_data;
    end
  end

  // x0 results complete the handshake but are dropped here.
  assign w_push = (w_src != SRC_NONE) && (w_push_rd != RZ);

  regfile_writeback_wb_fifo #(.DW(DW), .DEPTH(DEPTH)) u_wb_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({w_push_rd, w_push_data}),
    .pop       (write_enable),
    .head_data (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
`ifdef WB_FORWARD_EN
    ,
    .age_view  (w_age)
`endif
  );

  assign write_enable = !w_empty && !wb_stall;
  assign write_addr   = w_empty ? '0 : w_head[DW-1 -: REG_AW];
  assign write_data   = w_empty ? '0 : w_head[XLEN-1:0];
  assign wb_count     = w_count;

  // Clear first, then set: an issue to the rd committing this edge wins.
  always_comb begin
    w_busy_next = r_busy;
    if (write_enable) w_busy_next[write_addr] = 1'b0;
    if (issue_valid && issue_rd != RZ) w_busy_next[issue_rd] = 1'b1;
    w_busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end

  assign busy_mask = r_busy;

`ifdef WB_FORWARD_EN
  logic [1:0][REG_AW-1:0] w_fwd_addr;
  logic [1:0]             w_fwd_hit;
  logic [1:0][XLEN-1:0]   w_fwd_data;

  assign w_fwd_addr = {fwd_addr2, fwd_addr1};

  // Scan oldest to newest so the youngest matching entry overwrites.
  always_comb begin
    w_fwd_hit  = '0;
    w_fwd_data = '0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if ((($clog2(DEPTH)+1)'(k) < w_count) && (w_fwd_addr[p] != RZ) &&
            (w_age[k][DW-1 -: REG_AW] == w_fwd_addr[p])) begin
          w_fwd_hit[p]  = 1'b1;
          w_fwd_data[p] = w_age[k][XLEN-1:0];
        end
      end
    end
  end

  assign fwd_hit1  = w_fwd_hit[0];
  assign fwd_hit2  = w_fwd_hit[1];
  assign fwd_data1 = w_fwd_data[0];
  assign fwd_data2 = w_fwd_data[1];
`endif
endmodule
